// File: rtl/uart_bus_master_if.sv
// Port bundle between uart_bus_master, its UART rx/tx endpoints and the bus.
// master: the bridge itself; slave: UART endpoints plus bus responder.
interface uart_bus_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                    rx_valid;
   logic [7:0]              rx_data;
   logic                    tx_valid;
   logic [7:0]              tx_data;
   logic                    tx_busy;
   logic                    readEnable;
   logic                    writeEnable;
   logic [DATA_WIDTH/8-1:0] writeByteEnable;
   logic [ADDR_WIDTH-1:0]   address;
   logic [DATA_WIDTH-1:0]   writeData;
   logic [DATA_WIDTH-1:0]   readData;
   logic                    busy;

   modport master (
      input  rx_valid, rx_data, tx_busy, readData,
      output tx_valid, tx_data, readEnable, writeEnable,
      output writeByteEnable, address, writeData, busy
   );

   modport slave (
      output rx_valid, rx_data, tx_busy, readData,
      input  tx_valid, tx_data, readEnable, writeEnable,
      input  writeByteEnable, address, writeData, busy
   );
endinterface

// File: rtl/uart_bus_master.sv
// UART byte-frame to single-access bus bridge: 'W'/'R' frames, ACK/NAK/read data back.
// One bus strobe per frame; inter-byte timeout drops partial frames silently.
module uart_bus_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic               clock,
   input logic               reset,
   uart_bus_master_if.master bus
);
   localparam int AB = ADDR_WIDTH / 8;
   localparam int DB = DATA_WIDTH / 8;
   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, WDATA, BUS_WR, BUS_RD, RD_WAIT, RESP
   } state_t;

   state_t                state_q, state_d;
   logic                  wr_q, wr_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [31:0]           tmo_q, tmo_d;
   logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] resp_q, resp_d;
   logic [2:0]            left_q, left_d;
   logic                  gap_q, gap_d;
   logic                  fire;
   logic                  live;
   logic [ADDR_WIDTH-1:0] addr_in;
   logic [DATA_WIDTH-1:0] data_in;

   function automatic logic [DATA_WIDTH-1:0] top_byte(input logic [7:0] b);
      return DATA_WIDTH'(b) << (DATA_WIDTH - 8);
   endfunction

   assign addr_in = (addr_sh_q << 8) | ADDR_WIDTH'(bus.rx_data);
   assign data_in = (data_sh_q << 8) | DATA_WIDTH'(bus.rx_data);

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      addr_sh_d = addr_sh_q;
      addr_d    = addr_q;
      data_sh_d = data_sh_q;
      wdata_d   = wdata_q;
      resp_d    = resp_q;
      left_d    = left_q;
      gap_d     = 1'b0;
      fire      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
                  state_d = ADDR;
                  wr_d    = (bus.rx_data == CMD_WR);
                  cnt_d   = '0;
                  tmo_d   = '0;
               end else begin
                  state_d = RESP;
                  resp_d  = top_byte(NAK);
                  left_d  = 3'd1;
               end
            end
         end
         ADDR: begin
            if (bus.rx_valid) begin
               tmo_d     = '0;
               addr_sh_d = addr_in;
               cnt_d     = cnt_q + 3'd1;
               if (cnt_q == 3'(AB - 1)) begin
                  cnt_d = '0;
                  if (wr_q) begin
                     state_d = WDATA;
                  end else begin
                     addr_d  = addr_in;
                     state_d = BUS_RD;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         WDATA: begin
            if (bus.rx_valid) begin
               tmo_d     = '0;
               data_sh_d = data_in;
               cnt_d     = cnt_q + 3'd1;
               if (cnt_q == 3'(DB - 1)) begin
                  addr_d  = addr_sh_q;
                  wdata_d = data_in;
                  state_d = BUS_WR;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         BUS_WR: begin
            state_d = RESP;
            resp_d  = top_byte(ACK);
            left_d  = 3'd1;
         end
         BUS_RD: begin
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            state_d = RESP;
            resp_d  = bus.readData;
            left_d  = 3'(DB);
         end
         RESP: begin
            // gap_q forces one quiet cycle after every pulse
            if (!gap_q && !bus.tx_busy) begin
               fire   = 1'b1;
               gap_d  = 1'b1;
               resp_d = resp_q << 8;
               left_d = left_q - 3'd1;
               if (left_q == 3'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         wr_q      <= 1'b0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         addr_sh_q <= '0;
         addr_q    <= '0;
         data_sh_q <= '0;
         wdata_q   <= '0;
         resp_q    <= '0;
         left_q    <= '0;
         gap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         addr_sh_q <= addr_sh_d;
         addr_q    <= addr_d;
         data_sh_q <= data_sh_d;
         wdata_q   <= wdata_d;
         resp_q    <= resp_d;
         left_q    <= left_d;
         gap_q     <= gap_d;
      end
   end

   // outputs are forced low for the whole reset cycle, not just after the edge
   assign live                = ~reset;
   assign bus.tx_valid        = fire & live;
   assign bus.tx_data         = (fire & live) ? resp_q[DATA_WIDTH-1 -: 8] : 8'h00;
   assign bus.readEnable      = (state_q == BUS_RD) & live;
   assign bus.writeEnable     = (state_q == BUS_WR) & live;
   assign bus.writeByteEnable = ((state_q == BUS_WR) & live) ? '1 : '0;
   assign bus.address         = live ? addr_q : '0;
   assign bus.writeData       = live ? wdata_q : '0;
   assign bus.busy            = (state_q != IDLE) & live;
endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the bus data width; it SHALL be 8, 16 or 32.
REQ-002 Parameter ADDR_WIDTH, default 32, sets the bus address width; it SHALL be 8, 16 or 32.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, SHALL be the inter-byte idle limit in clocks.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 rx_valid  input  1  one-cycle strobe: received byte present (from uart_rx).
REQ-007 rx_data  input  8  received byte.
REQ-008 tx_valid  output  1  one-cycle strobe: byte to send (to uart_tx).
REQ-009 tx_data  output  8  byte to send; valid while tx_valid is high.
REQ-010 tx_busy  input  1  transmitter busy (from uart_tx).
REQ-011 readEnable  output  1  bus read strobe.
REQ-012 writeEnable  output  1  bus write strobe.
REQ-013 writeByteEnable  output  DATA_WIDTH/8  byte enables.
REQ-014 address  output  ADDR_WIDTH  bus address.
REQ-015 writeData  output  DATA_WIDTH  bus write data.
REQ-016 readData  input  DATA_WIDTH  bus read data, registered by the responder.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 Frame format: command byte; then ADDR_WIDTH/8 address bytes, MSB first; for a write only, DATA_WIDTH/8 data bytes follow, MSB first.
REQ-019 Commands: 0x57 = write, 0x52 = read; any other command byte SHALL send the single byte 0x15 (NAK) with no bus access.
REQ-020 States: IDLE, ADDR, WDATA, BUS_WR, BUS_RD, RD_WAIT, RESP; the FSM SHALL transition only on clock edges.
REQ-021 IDLE -> ADDR on rx_valid with 0x57 or 0x52; IDLE -> RESP (NAK) on any other rx_valid.
REQ-022 ADDR collects bytes by shifting them in; after the last address byte: write -> WDATA, read -> BUS_RD.
REQ-023 WDATA collects bytes by shifting them in; after the last data byte -> BUS_WR.
REQ-024 BUS_WR: writeEnable high for exactly one cycle; writeByteEnable all ones; address and writeData stable in that cycle; next state RESP with the single byte 0x06 (ACK).
REQ-025 BUS_RD: readEnable high for exactly one cycle; RD_WAIT captures readData on the following cycle; next state RESP with DATA_WIDTH/8 bytes, MSB first.
REQ-026 Outside the strobe cycle, readEnable, writeEnable and writeByteEnable SHALL be 0; address and writeData hold their last values.
REQ-027 TX rule: pulse tx_valid for one cycle only when tx_busy is 0; after each pulse, hold one cycle with tx_valid low before the next byte is eligible.
REQ-028 RESP -> IDLE one cycle after the last response byte's tx_valid pulse.
REQ-029 rx_valid in BUS_WR, BUS_RD, RD_WAIT or RESP: the byte SHALL be dropped with no state effect.
REQ-030 Timeout: in ADDR or WDATA, a counter clears on each rx_valid and increments otherwise; at TIMEOUT_CYCLES idle clocks -> IDLE, no bus access, no response.
REQ-031 An rx_valid that coincides with the timeout cycle SHALL be accepted and SHALL clear the counter (no timeout).
REQ-032 Only one bus access SHALL be issued per frame; there are no retries.

Reset
REQ-033 While reset is high, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the counter and shift registers SHALL be cleared.
REQ-034 Reset in any state SHALL abort the frame: no further bus strobes and no further tx_valid pulses.

Verification
REQ-035 Write frame 57 90 00 00 20 00 00 00 41 -> one writeEnable cycle with address 0x90000020, writeData 0x00000041, writeByteEnable 0xF; then tx_data 0x06.
REQ-036 Read frame 52 90 00 00 14, with readData=0x00000001 on the cycle after readEnable -> tx bytes 00 00 00 01 in order; busy returns to 0.
REQ-037 Command 0x3F -> single tx byte 0x15; readEnable and writeEnable stay 0.
REQ-038 Bytes 57 90 00 then TIMEOUT_CYCLES idle clocks -> IDLE with no bus strobe; a following read frame completes normally.
REQ-039 tx_busy held high 50 cycles during RESP -> no tx_valid pulse during those cycles; the next byte is sent after tx_busy falls.
REQ-040 Reset asserted after 2 of the 4 read response bytes -> no further tx_valid pulses; all outputs 0; busy 0.
